// File: rtl/apb_pkg.sv
// apb_pkg: shared widths, FSM state type and address helper for the APB register-file slave.
package apb_pkg;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;
    localparam int APB_IDX_W  = APB_ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_slv_state_e;

    function automatic logic [APB_IDX_W-1:0] apb_word_idx(input logic [APB_ADDR_W-1:0] addr);
        return addr[APB_ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// apb_slv_regbank: NREG-1 writable 32-bit registers with byte strobes, plus a constant ID word
// at index NREG-1; combinational read mux returning 0 for unmapped indices.
module apb_slv_regbank
    import apb_pkg::*;
#(
    parameter int                    NREG   = 8,
    parameter logic [APB_DATA_W-1:0] ID_VAL = 32'hA5B0_0001
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  i_we,
    input  logic [APB_IDX_W-1:0]  i_idx,
    input  logic [APB_DATA_W-1:0] i_wdata,
    input  logic [APB_STRB_W-1:0] i_strb,
    output logic [APB_DATA_W-1:0] o_rdata
);

    logic [APB_DATA_W-1:0] r_regs [NREG-1];

    // Byte-lane writes into the writable registers.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < NREG - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG - 1; i++) begin
                for (int b = 0; b < APB_STRB_W; b++) begin
                    if (i_we && (i_idx == APB_IDX_W'(i)) && i_strb[b]) begin
                        r_regs[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end else begin
                        r_regs[i][b*8 +: 8] <= r_regs[i][b*8 +: 8];
                    end
                end
            end
        end
    end

    // One-hot OR read mux over the register array and the ID word.
    always_comb begin
        o_rdata = (i_idx == APB_IDX_W'(NREG - 1)) ? ID_VAL : {APB_DATA_W{1'b0}};
        for (int i = 0; i < NREG - 1; i++) begin
            o_rdata = o_rdata | ((i_idx == APB_IDX_W'(i)) ? r_regs[i] : {APB_DATA_W{1'b0}});
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB slave over NREG 32-bit registers, the last one a read-only ID.
// Wait states are compiled in only when APB_SLV_WAIT_EN is defined.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    NREG     = 8,
    parameter int                    WAIT_CYC = 2,
    parameter logic [APB_DATA_W-1:0] ID_VAL   = 32'hA5B0_0001
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_STRB_W-1:0] pstrb,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    apb_slv_state_e        r_state;
    logic [APB_ADDR_W-1:0] r_addr;
    logic                  r_write;
    logic [APB_DATA_W-1:0] r_wdata;
    logic [APB_STRB_W-1:0] r_strb;
    logic [APB_DATA_W-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;

    logic [APB_IDX_W-1:0]  w_idx;
    logic [APB_DATA_W-1:0] w_rdata;
    logic [APB_DATA_W-1:0] w_resp_data;
    logic                  w_err;
    logic                  w_setup;
    logic                  w_capture;
    logic                  w_we;
    logic                  w_wait_done;

    assign w_setup     = psel && !penable;
    assign w_capture   = w_setup && ((r_state == IDLE) || ((r_state == ACCESS) && r_pready));
    assign w_idx       = apb_word_idx(r_addr);
    assign w_err       = (r_addr[1:0] != 2'b00)
                      || (w_idx >= APB_IDX_W'(NREG))
                      || (r_write && (w_idx == APB_IDX_W'(NREG - 1)));
    assign w_resp_data = (w_err || r_write) ? {APB_DATA_W{1'b0}} : w_rdata;
    // A write lands on the edge that closes its pready cycle, never on an errored one.
    assign w_we        = (r_state == ACCESS) && r_pready && r_write && !r_pslverr;

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);
    logic [3:0] r_wait_cnt;

    // Counts ACCESS cycles of the current transfer, cleared in SETUP and held at LP_WAIT.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == SETUP) begin
            r_wait_cnt <= 4'd0;
        end else if ((r_state == ACCESS) && (r_wait_cnt != LP_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    assign w_wait_done = (r_state == SETUP) ? (LP_WAIT == 4'd0)
                                            : (({1'b0, r_wait_cnt} + 5'd1) >= {1'b0, LP_WAIT});
`else
    // Without the wait feature WAIT_CYC has no effect: every transfer is zero-wait.
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC) & 4'd0;
    assign w_wait_done = (LP_WAIT == 4'd0);
`endif

    // Latches the request presented in the bus setup phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_capture) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
        end else begin
            r_addr  <= r_addr;
            r_write <= r_write;
            r_wdata <= r_wdata;
            r_strb  <= r_strb;
        end
    end

    // Transfer FSM with registered pready/pslverr/prdata.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state   <= IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    r_state   <= w_setup ? SETUP : IDLE;
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_pready  <= w_wait_done;
                    r_pslverr <= w_wait_done && w_err;
                    r_prdata  <= w_wait_done ? w_resp_data : {APB_DATA_W{1'b0}};
                end
                ACCESS: begin
                    if (r_pready) begin
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                        r_state   <= w_setup ? SETUP : IDLE;
                    end else if (!(psel && penable)) begin
                        // Master gave up before completion: drop the transfer.
                        r_state   <= IDLE;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                    end else if (w_wait_done) begin
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= w_resp_data;
                    end else begin
                        r_state   <= ACCESS;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
            endcase
        end
    end

    apb_slv_regbank #(
        .NREG   (NREG),
        .ID_VAL (ID_VAL)
    ) u_regbank (
        .hclk    (hclk),
        .hreset  (hreset),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .i_strb  (r_strb),
        .o_rdata (w_rdata)
    );

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed APB transfers against a reference register model with a
// scoreboard queue of expected responses.
module tb_apb_slave_regfile;
    import apb_pkg::*;

    localparam int          NREG     = 8;
    localparam int          WAIT_CYC = 2;
    localparam logic [31:0] ID_VAL   = 32'hA5B0_0001;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = WAIT_CYC;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic                  hclk = 1'b0;
    logic                  hreset = 1'b1;
    logic                  psel = 1'b0;
    logic                  penable = 1'b0;
    logic                  pwrite = 1'b0;
    logic [APB_ADDR_W-1:0] paddr = '0;
    logic [APB_DATA_W-1:0] pwdata = '0;
    logic [APB_STRB_W-1:0] pstrb = '0;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [NREG-1];
    int          total = 0;
    int          bad = 0;

    apb_slave_regfile #(.NREG(NREG), .WAIT_CYC(WAIT_CYC), .ID_VAL(ID_VAL)) dut (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;

    task automatic mdl_reset();
        for (int i = 0; i < NREG - 1; i++) mdl[i] = 32'h0;
    endtask

    // One APB transfer starting at a falling edge; b2b leaves psel high for an immediate follow-on.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit b2b, input string name);
        exp_t        e;
        exp_t        g;
        logic [9:0]  idx;
        int          k;
        bit          seen;
        idx   = addr[11:2];
        e.err = (addr[1:0] != 2'b00) || (idx >= 10'd8) || (wr && (idx == 10'd7));
        e.rd  = 32'h0;
        if (!wr && !e.err) e.rd = (idx == 10'd7) ? ID_VAL : mdl[int'(idx)];
        sb_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge hclk);
        total++;
        if (pready !== 1'b0 || prdata !== 32'h0) begin
            bad++;
            $display("FAIL %s idle_out: pready=%b prdata=%h, required 0/0", name, pready, prdata);
        end
        penable = 1'b1;
        // Scramble bus fields in the access phase; the slave must use the captured ones.
        paddr  = addr ^ 12'h004;
        pwdata = ~data;
        pstrb  = ~strb;
        seen = 1'b0;
        k = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge hclk);
            if (pready === 1'b1) begin
                seen = 1'b1;
                k = c;
            end
        end
        e = sb_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: pready not seen in 20 cycles, required after %0d", name, EXP_WAIT + 1);
        end else begin
            g.rd  = prdata;
            g.err = pslverr;
            if (k != EXP_WAIT + 1) begin
                bad++;
                $display("FAIL %s latency: pready at cycle %0d, required %0d", name, k, EXP_WAIT + 1);
            end
            total++;
            if (g.rd !== e.rd || g.err !== e.err) begin
                bad++;
                $display("FAIL %s resp: prdata=%h pslverr=%b, required %h/%b", name, g.rd, g.err, e.rd, e.err);
            end
            if (wr && !e.err) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mdl[int'(idx)][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        if (!b2b) begin
            psel = 1'b0;
            penable = 1'b0;
        end
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        repeat (2) @(negedge hclk);
        total++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_out: pready=%b pslverr=%b prdata=%h, required 0/0/0", pready, pslverr, prdata);
        end
        hreset = 1'b0;
        mdl_reset();
        @(negedge hclk);
        for (int i = 0; i < NREG; i++) apb_xfer(1'b0, 12'(i * 4), 32'h0, 4'h0, 1'b0, "reset_rd");
    endtask

    task automatic test_write_read();
        apb_xfer(1'b1, 12'h004, 32'h1234_5678, 4'hF, 1'b0, "wr_004");
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, "rd_004");
        apb_xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 1'b0, "wr_010");
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, "rd_010");
    endtask

    task automatic test_strobe();
        apb_xfer(1'b1, 12'h008, 32'hFFFF_FFFF, 4'b0101, 1'b0, "wr_008_strb");
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, "rd_008");
        apb_xfer(1'b1, 12'h010, 32'h1122_3344, 4'b0010, 1'b0, "wr_010_strb");
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, "rd_010_strb");
    endtask

    task automatic test_errors();
        apb_xfer(1'b0, 12'h002, 32'h0, 4'h0, 1'b0, "rd_misalign");
        apb_xfer(1'b1, 12'h005, 32'hAAAA_AAAA, 4'hF, 1'b0, "wr_misalign");
        apb_xfer(1'b1, 12'h020, 32'hBBBB_BBBB, 4'hF, 1'b0, "wr_oor");
        apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, "rd_oor");
        apb_xfer(1'b1, 12'h01C, 32'hCCCC_CCCC, 4'hF, 1'b0, "wr_id");
        for (int i = 0; i < NREG; i++) apb_xfer(1'b0, 12'(i * 4), 32'h0, 4'h0, 1'b0, "rd_after_err");
    endtask

    task automatic test_back_to_back();
        apb_xfer(1'b1, 12'h000, 32'hCAFE_F00D, 4'hF, 1'b1, "b2b_wr");
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, "b2b_rd");
        apb_xfer(1'b1, 12'h018, 32'h0BAD_1DEA, 4'b1100, 1'b1, "b2b_wr2");
        apb_xfer(1'b0, 12'h018, 32'h0, 4'h0, 1'b0, "b2b_rd2");
    endtask

`ifdef APB_SLV_WAIT_EN
    task automatic test_abort();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        psel = 1'b0;
        penable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge hclk);
            total++;
            if (pready !== 1'b0 || pslverr !== 1'b0) begin
                bad++;
                $display("FAIL abort_out: pready=%b pslverr=%b, required 0/0", pready, pslverr);
            end
        end
        apb_xfer(1'b0, 12'h014, 32'h0, 4'h0, 1'b0, "rd_after_abort");
    endtask
`endif

    task automatic test_reset_midxfer();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h5A5A_A5A5; pstrb = 4'hF;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        hreset = 1'b1;
        #1;
        total++;
        if (pready !== 1'b0 || prdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_out: pready=%b prdata=%h, required 0/0", pready, prdata);
        end
        @(negedge hclk);
        psel = 1'b0;
        penable = 1'b0;
        @(negedge hclk);
        hreset = 1'b0;
        mdl_reset();
        @(negedge hclk);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, "rd_00C_after_rst");
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, "rd_004_after_rst");
        apb_xfer(1'b1, 12'h00C, 32'h0102_0304, 4'hF, 1'b0, "wr_00C_after_rst");
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, "rd_00C_final");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_back_to_back();
`ifdef APB_SLV_WAIT_EN
        test_abort();
`endif
        test_reset_midxfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter NREG, default 8: number of 32-bit registers (word offsets 0x00..(NREG-1)*4).
REQ-002 SHALL have parameter WAIT_CYC, default 2: wait states per access (0..15), used only when the wait feature is compiled in.
REQ-003 SHALL have parameter ID_VAL, default 32'hA5B0_0001: read-only value of the last register.
REQ-004 SHALL use one clock and an asynchronous, active-high reset. hclk is the single clock, rising-edge. hreset is the reset.
REQ-005 SHALL have the following ports:
- hclk  in  1  clock
- hreset  in  1  async active-high reset
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  12  byte address
- pwdata  in  32  write data
- pstrb  in  4  byte-lane write strobes
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error

Function
REQ-006 SHALL implement an FSM with states IDLE, SETUP, ACCESS.
REQ-007 SHALL handle transitions as follows:
- IDLE->SETUP on psel=1 & penable=0.
- SETUP->ACCESS unconditionally.
- ACCESS->IDLE on the cycle pready=1 when psel=0 next; ACCESS->SETUP when psel=1 & penable=0 next (back-to-back).
REQ-008 SHALL capture paddr/pwrite/pwdata/pstrb in SETUP; later changes during ACCESS are ignored.
REQ-009 SHALL assert pready (registered) after exactly WAIT_CYC ACCESS cycles; WAIT_CYC=0 gives pready=1 in the first ACCESS cycle.
REQ-010 SHALL hold pready=0 outside ACCESS, and hold it high for exactly one cycle per transfer.
REQ-011 SHALL return prdata as the addressed register value in the pready=1 cycle of a read, and 0 in all other cycles.
REQ-012 SHALL update a write at the rising edge ending the pready=1 cycle, and only the byte lanes with pstrb[i]=1.
REQ-013 SHALL assert pslverr=1 only with pready=1, and SHALL do so for any of:
- paddr[1:0]!=0
- word index >= NREG
- a write to the ID register (index NREG-1)
REQ-014 SHALL NOT change any register on an errored write, and SHALL return prdata=0 on an errored read.
REQ-015 SHALL, if psel or penable drops while in ACCESS before pready, abort to IDLE with no write and pready/pslverr=0.
REQ-016 SHALL reset the wait counter on every SETUP, and the counter SHALL never wrap past WAIT_CYC.

Reset
REQ-017 SHALL, while hreset=1 (asynchronous), set the FSM to IDLE, pready=0, pslverr=0, prdata=0, the wait counter to 0, and registers 0..NREG-2 to 0.
REQ-018 SHALL treat reset asserted mid-transfer as an abort: no write commits and the bus restarts from IDLE.

Configuration
REQ-019 SHALL provide the APB_SLV_WAIT_EN macro:
- Defined: WAIT_CYC wait states are inserted per REQ-009.
- Undefined: the wait counter is removed and every transfer completes with pready=1 in the first ACCESS cycle, regardless of WAIT_CYC.

Structure
REQ-020 SHALL place the shared definitions in package apb_pkg:
- FSM state enum apb_slv_state_e (IDLE, SETUP, ACCESS)
- constants APB_ADDR_W=12, APB_DATA_W=32, APB_STRB_W=4
REQ-021 SHALL implement the register array with byte-strobe write and read mux in sub-module apb_slv_regbank; the FSM, wait counter and error decode stay in the top module.

Verification
REQ-022 SHALL cover the following directed scenarios with WAIT_CYC=2 and the macro defined:
- Write 0x1234_5678 to 0x004 with pstrb=4'hF, then read 0x004 -> prdata=0x1234_5678, pslverr=0, pready high 2 cycles after ACCESS entry.
- Write 0xFFFF_FFFF to 0x008 with pstrb=4'b0101, then read -> prdata=0x00FF_00FF.
- Read 0x002 (misaligned) -> pslverr=1, prdata=0. Write 0x020 (index 8) -> pslverr=1, no register changes.
- Write to 0x01C (ID register) -> pslverr=1. Read 0x01C -> 0xA5B0_0001.
- Back-to-back write 0x000 then read 0x000 with no idle cycle -> correct data and one pready pulse per transfer.
- Assert hreset during the ACCESS wait of a write to 0x00C -> pready=0 immediately, and a later read of 0x00C returns 0.
